// File: rtl/dffers_bank_ctrl_if.sv
// Command channel between the test/config master and the flop-bank sequencer.
// Carries the valid/ready command handshake and the done/err completion report.
interface dffers_bank_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic [HOLD_W-1:0] cmd_cnt;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_cnt,
        input  cmd_ready, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_cnt,
        output cmd_ready, done, err
    );
endinterface

// File: rtl/dffers_bank_ctrl.sv
// Command sequencer for a bank of enable/set/reset flops: drives D/E/Rn/Sn for
// LOAD/CLEAR/PRESET/HOLD commands, reads the bank back and counts mismatches.
module dffers_bank_ctrl #(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_W    = 8
) (
    input  logic               clk,
    input  logic               R,
    dffers_bank_ctrl_if.slave  cmd,
    output logic [WIDTH-1:0]   bank_D,
    output logic               bank_E,
    output logic               bank_Rn,
    output logic               bank_Sn,
    input  logic [WIDTH-1:0]   bank_Q,
    output logic [7:0]         fail_cnt
);

    localparam int PULSE_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam int CNT_W   = (HOLD_W > PULSE_W) ? HOLD_W : PULSE_W;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RECOVER = 2'd2,
        CHECK   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_PRESET = 2'b10,
        OP_HOLD   = 2'b11
    } op_t;

    state_t           state;
    op_t              op;
    logic [WIDTH-1:0] expect_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold_last;
    logic             accept;
    logic             mismatch;

    // The DRIVE counter runs down to zero, so it is loaded with length-1;
    // a HOLD count of zero behaves like one.
    assign hold_last = (cmd.cmd_cnt == '0) ? '0 : CNT_W'(cmd.cmd_cnt - HOLD_W'(1));
    assign accept    = cmd.cmd_valid & cmd.cmd_ready;
    assign mismatch  = (bank_Q != expect_q);

    always_ff @(posedge clk) begin
        if (R) begin
            state         <= IDLE;
            op            <= OP_LOAD;
            expect_q      <= '0;
            cnt           <= '0;
            cmd.cmd_ready <= 1'b0;
            cmd.done      <= 1'b0;
            cmd.err       <= 1'b0;
            bank_D        <= '0;
            bank_E        <= 1'b0;
            bank_Rn       <= 1'b1;
            bank_Sn       <= 1'b1;
            fail_cnt      <= '0;
        end else begin
            cmd.done <= 1'b0;
            cmd.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op            <= op_t'(cmd.cmd_op);
                        cmd.cmd_ready <= 1'b0;
                        state         <= DRIVE;
                        case (op_t'(cmd.cmd_op))
                            OP_LOAD: begin
                                bank_E   <= 1'b1;
                                bank_D   <= cmd.cmd_data;
                                expect_q <= cmd.cmd_data;
                                cnt      <= '0;
                            end
                            OP_CLEAR: begin
                                bank_Rn  <= 1'b0;
                                expect_q <= '0;
                                cnt      <= PULSE_LAST;
                            end
                            OP_PRESET: begin
                                bank_Sn  <= 1'b0;
                                expect_q <= '1;
                                cnt      <= PULSE_LAST;
                            end
                            default: begin
                                // HOLD must leave the bank exactly as it was at accept.
                                expect_q <= bank_Q;
                                cnt      <= hold_last;
                            end
                        endcase
                    end else begin
                        cmd.cmd_ready <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        bank_E  <= 1'b0;
                        bank_Rn <= 1'b1;
                        bank_Sn <= 1'b1;
                        if (op == OP_CLEAR || op == OP_PRESET) begin
                            state <= RECOVER;
                        end else begin
                            state <= CHECK;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RECOVER: begin
                    state <= CHECK;
                end
                CHECK: begin
                    state         <= IDLE;
                    cmd.cmd_ready <= 1'b1;
                    cmd.done      <= 1'b1;
                    cmd.err       <= mismatch;
                    if (mismatch && fail_cnt != 8'hFF) begin
                        fail_cnt <= fail_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dffers_bank_ctrl.sv
// Self-checking bench for dffers_bank_ctrl: directed scenarios plus random commands
// against a command-level model of the flop bank and the sequencer's timing.
module tb_dffers_bank_ctrl;

    localparam int WIDTH     = 8;
    localparam int PULSE_CYC = 2;
    localparam int HOLD_W    = 8;

    logic             clk = 1'b0;
    logic             R;
    logic [WIDTH-1:0] bank_D;
    logic             bank_E;
    logic             bank_Rn;
    logic             bank_Sn;
    logic [WIDTH-1:0] bank_Q;
    logic [7:0]       fail_cnt;
    logic [WIDTH-1:0] flopState;
    logic [WIDTH-1:0] stuck0;

    int checks = 0;
    int errors = 0;

    int               modelFail;
    logic [WIDTH-1:0] modelBank;
    logic [WIDTH-1:0] modelLastD;

    int               lat;
    int               eHigh;
    int               rnLow;
    int               snLow;
    int               badOverlap;
    int               badE;
    int               busyReady;
    logic             errAtDone;
    logic             readyAtDone;
    logic             eAtDone;
    logic [WIDTH-1:0] dAtDone;
    logic [WIDTH-1:0] qAtDone;
    logic [7:0]       failAtDone;
    bit               cmdOk;

    always #5 clk = ~clk;

    dffers_bank_ctrl_if #(.WIDTH(WIDTH), .HOLD_W(HOLD_W)) cmdIf ();

    dffers_bank_ctrl #(
        .WIDTH(WIDTH),
        .PULSE_CYC(PULSE_CYC),
        .HOLD_W(HOLD_W)
    ) dut (
        .clk(clk),
        .R(R),
        .cmd(cmdIf),
        .bank_D(bank_D),
        .bank_E(bank_E),
        .bank_Rn(bank_Rn),
        .bank_Sn(bank_Sn),
        .bank_Q(bank_Q),
        .fail_cnt(fail_cnt)
    );

    // Behavioural flop bank with active-low async reset/set and optional stuck-at-0 bits.
    always @(posedge clk or negedge bank_Rn or negedge bank_Sn) begin
        if (!bank_Rn) flopState <= '0;
        else if (!bank_Sn) flopState <= '1;
        else if (bank_E) flopState <= bank_D;
    end
    assign bank_Q = flopState & ~stuck0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one command, waits for acceptance and completion, and records what the bank saw.
    task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] data,
                                 input logic [HOLD_W-1:0] cnt, output bit ok);
        logic acceptNow;
        int   waitCyc;
        ok = 1'b0;
        cmdIf.cmd_valid = 1'b1;
        cmdIf.cmd_op    = op;
        cmdIf.cmd_data  = data;
        cmdIf.cmd_cnt   = cnt;
        acceptNow = 1'b0;
        waitCyc   = 0;
        while (!acceptNow && waitCyc < 50) begin
            acceptNow = cmdIf.cmd_ready;
            tick();
            waitCyc++;
        end
        cmdIf.cmd_valid = 1'b0;
        if (!acceptNow) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            return;
        end
        lat = 1; eHigh = 0; rnLow = 0; snLow = 0; badOverlap = 0; badE = 0; busyReady = 0;
        while (!cmdIf.done && lat < 600) begin
            if (bank_E) eHigh++;
            if (!bank_Rn) rnLow++;
            if (!bank_Sn) snLow++;
            if (!bank_Rn && !bank_Sn) badOverlap++;
            if (bank_E && (!bank_Rn || !bank_Sn)) badE++;
            if (cmdIf.cmd_ready) busyReady++;
            tick();
            lat++;
        end
        if (!cmdIf.done) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
            return;
        end
        errAtDone   = cmdIf.err;
        readyAtDone = cmdIf.cmd_ready;
        eAtDone     = bank_E;
        dAtDone     = bank_D;
        qAtDone     = bank_Q;
        failAtDone  = fail_cnt;
        ok = 1'b1;
    endtask

    // Reference model: expected outcome of a command computed from the bank's rules.
    task automatic runCommand(input logic [1:0] op, input logic [WIDTH-1:0] data,
                              input logic [HOLD_W-1:0] cnt);
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] visible;
        int expLat, expE, expRn, expSn;
        logic expErr;
        case (op)
            2'b00: begin target = data; visible = data & ~stuck0; expLat = 3; end
            2'b01: begin target = '0; visible = '0; expLat = PULSE_CYC + 3; end
            2'b10: begin target = '1; visible = '1 & ~stuck0; expLat = PULSE_CYC + 3; end
            default: begin
                target = modelBank; visible = modelBank;
                expLat = ((cnt == 0) ? 1 : int'(cnt)) + 2;
            end
        endcase
        expE   = (op == 2'b00) ? 1 : 0;
        expRn  = (op == 2'b01) ? PULSE_CYC : 0;
        expSn  = (op == 2'b10) ? PULSE_CYC : 0;
        expErr = (visible != target);
        if (expErr && modelFail < 255) modelFail++;
        modelBank = visible;
        if (op == 2'b00) modelLastD = data;

        applyStimulus(op, data, cnt, cmdOk);
        if (!cmdOk) return;
        checkOutput("latency", lat, expLat);
        checkOutput("e_cycles", eHigh, expE);
        checkOutput("rn_cycles", rnLow, expRn);
        checkOutput("sn_cycles", snLow, expSn);
        checkOutput("rn_sn_overlap", badOverlap, 0);
        checkOutput("e_during_rs", badE, 0);
        checkOutput("ready_while_busy", busyReady, 0);
        checkOutput("err", errAtDone, expErr);
        checkOutput("ready_at_done", readyAtDone, 1);
        checkOutput("e_at_done", eAtDone, 0);
        checkOutput("bank_q", qAtDone, modelBank);
        checkOutput("bank_d", dAtDone, modelLastD);
        checkOutput("fail_cnt", failAtDone, modelFail);
    endtask

    initial begin
        logic [1:0]       rop;
        logic [WIDTH-1:0] rdata;
        logic [HOLD_W-1:0] rcnt;

        R = 1'b1;
        stuck0 = '0;
        cmdIf.cmd_valid = 1'b0;
        cmdIf.cmd_op    = 2'b00;
        cmdIf.cmd_data  = '0;
        cmdIf.cmd_cnt   = '0;
        modelFail  = 0;
        modelBank  = '0;
        modelLastD = '0;

        $display("[TB] reset");
        repeat (3) tick();
        checkOutput("rst_ready", cmdIf.cmd_ready, 0);
        checkOutput("rst_e", bank_E, 0);
        checkOutput("rst_rn", bank_Rn, 1);
        checkOutput("rst_sn", bank_Sn, 1);
        checkOutput("rst_d", bank_D, 0);
        checkOutput("rst_done", cmdIf.done, 0);
        checkOutput("rst_fail_cnt", fail_cnt, 0);
        R = 1'b0;
        tick();
        checkOutput("ready_after_rst", cmdIf.cmd_ready, 1);

        $display("[TB] load / clear / preset");
        runCommand(2'b00, 8'hA5, 8'd0);
        runCommand(2'b00, 8'hFF, 8'd0);
        runCommand(2'b01, 8'h00, 8'd0);
        runCommand(2'b10, 8'h00, 8'd0);

        $display("[TB] hold");
        runCommand(2'b00, 8'h5A, 8'd0);
        runCommand(2'b11, 8'hC3, 8'd5);
        runCommand(2'b11, 8'h00, 8'd0);
        runCommand(2'b11, 8'h00, 8'd1);

        $display("[TB] stuck bit and saturation");
        stuck0 = 8'h08;
        modelBank = modelBank & ~stuck0;
        runCommand(2'b00, 8'h08, 8'd0);
        for (int i = 1; i < 300; i++) runCommand(2'b00, 8'h08, 8'd0);
        stuck0 = '0;

        $display("[TB] reset mid-command");
        cmdIf.cmd_valid = 1'b1;
        cmdIf.cmd_op    = 2'b01;
        tick();
        checkOutput("abort_rn_low", bank_Rn, 0);
        cmdIf.cmd_op   = 2'b00;
        cmdIf.cmd_data = 8'h3C;
        R = 1'b1;
        tick();
        checkOutput("abort_rn_released", bank_Rn, 1);
        checkOutput("abort_ready", cmdIf.cmd_ready, 0);
        checkOutput("abort_done", cmdIf.done, 0);
        tick();
        checkOutput("abort_done_later", cmdIf.done, 0);
        checkOutput("abort_fail_cleared", fail_cnt, 0);
        R = 1'b0;
        modelBank = '0;
        modelFail = 0;
        modelLastD = '0;
        runCommand(2'b00, 8'h3C, 8'd0);

        $display("[TB] random commands");
        for (int i = 0; i < 60; i++) begin
            rop   = 2'($urandom_range(0, 3));
            rdata = WIDTH'($urandom);
            rcnt  = HOLD_W'($urandom_range(0, 6));
            repeat ($urandom_range(0, 2)) tick();
            runCommand(rop, rdata, rcnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
